// File: rtl/sram_sp_be.sv
// Single-port synchronous SRAM with byte-lane write enables,
// a 1/2-cycle read pipeline and a post-reset hardware clear sequencer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         request strobe, accepted only when busy=0
//   we         1 = write, 0 = read
//   be         byte-lane write enables, be[i] covers din[8i+7:8i]
//   addr       word address
//   din        write data
//   dout       returned word, held between dout_valid pulses
//   dout_valid one-cycle pulse marking a returned word
//   busy       high while the clear sequencer owns the array
module sram_sp_be #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned WORD_DEPTH  = 16,
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned WRITE_FIRST = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [WORD_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [WORD_WIDTH-1:0]   din,
    output logic [WORD_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int unsigned NB = WORD_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
        ADDR_WIDTH'(WORD_DEPTH - 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT =
        (ADDR_WIDTH + 1)'(WORD_DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic                    clr_we;

    logic [WORD_WIDTH-1:0]   mem_q [WORD_DEPTH];

    logic                    acc;
    logic                    in_range;
    logic [WORD_WIDTH-1:0]   old_word;
    logic [WORD_WIDTH-1:0]   merged;
    logic [WORD_WIDTH-1:0]   rd_word;

    logic                    out_load;
    logic [WORD_WIDTH-1:0]   out_data;
    logic                    dout_valid_q;
    logic [WORD_WIDTH-1:0]   dout_q;

    // ------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // rst is folded in so requests are refused during reset itself,
    // not only from the first reset edge onward.
    assign busy = rst | (state_q == ST_CLEAR);
    assign acc  = en & ~busy;

    // ------------------------------------------------------------
    // Array access
    // ------------------------------------------------------------
    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign old_word = in_range ? mem_q[addr] : '0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Word returned for this request: post-merge for writes only
    // in write-first mode; out-of-range always returns zero.
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            if (we && (WRITE_FIRST != 0)) begin
                rd_word = merged;
            end else begin
                rd_word = old_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cnt_q] <= '0;
            end else if (acc && we && in_range) begin
                mem_q[addr] <= merged;
            end
        end
    end

    // ------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------
    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            logic                  s1_vld_q;
            logic [WORD_WIDTH-1:0] s1_data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q <= acc;
                    if (acc) begin
                        s1_data_q <= rd_word;
                    end
                end
            end

            assign out_load = s1_vld_q;
            assign out_data = s1_data_q;
        end else begin : g_lat1
            assign out_load = acc;
            assign out_data = rd_word;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            dout_valid_q <= out_load;
            if (out_load) begin
                dout_q <= out_data;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sram_sp_be.sv
// Directed bench for sram_sp_be: two instances share one stimulus,
// an 8-bit/lat-1/read-first array and a 32-bit/lat-2/write-first one.
module tb_sram_sp_be;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] din;

    logic [7:0]  dout0;
    logic        dv0;
    logic        busy0;
    logic [31:0] dout1;
    logic        dv1;
    logic        busy1;

    int n_assert;
    int n_fail;

    // expected-state model
    logic [7:0]  hold0;
    logic [31:0] hold1;
    logic        p1v;
    logic [31:0] p1d;
    int          bz0;
    int          bz1;

    sram_sp_be #(
        .ADDR_WIDTH (4),
        .WORD_DEPTH (16),
        .WORD_WIDTH (8),
        .RD_LATENCY (1),
        .WRITE_FIRST(0)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .be        (be[0:0]),
        .addr      (addr),
        .din       (din[7:0]),
        .dout      (dout0),
        .dout_valid(dv0),
        .busy      (busy0)
    );

    sram_sp_be #(
        .ADDR_WIDTH (4),
        .WORD_DEPTH (12),
        .WORD_WIDTH (32),
        .RD_LATENCY (2),
        .WRITE_FIRST(1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .din       (din),
        .dout      (dout1),
        .dout_valid(dv1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold rst for n edges; both arrays must show the reset state.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_d0_valid", 32'(dv0), 32'd0);
            chk("rst_d0_dout", 32'(dout0), 32'd0);
            chk("rst_d0_busy", 32'(busy0), 32'd1);
            chk("rst_d1_valid", 32'(dv1), 32'd0);
            chk("rst_d1_dout", dout1, 32'd0);
            chk("rst_d1_busy", 32'(busy1), 32'd1);
        end
        rst   = 1'b0;
        hold0 = 8'h00;
        hold1 = 32'h0;
        p1v   = 1'b0;
        p1d   = 32'h0;
        bz0   = 16;
        bz1   = 12;
    endtask

    // One cycle. x0/x1 are the hand-computed words each array must
    // return for this request if it is accepted.
    task automatic step(input logic        e,
                        input logic        w,
                        input logic [3:0]  b,
                        input logic [3:0]  a,
                        input logic [31:0] d,
                        input logic [31:0] x0,
                        input logic [31:0] x1);
        logic a0;
        logic a1;
        en   = e;
        we   = w;
        be   = b;
        addr = a;
        din  = d;
        a0   = e && (bz0 == 0);
        a1   = e && (bz1 == 0);
        chk("d0_busy", 32'(busy0), 32'(bz0 != 0));
        chk("d1_busy", 32'(busy1), 32'(bz1 != 0));
        @(posedge clk);
        #1;
        if (bz0 > 0) bz0--;
        if (bz1 > 0) bz1--;
        if (a0) hold0 = x0[7:0];
        chk("d0_valid", 32'(dv0), 32'(a0));
        chk("d0_dout", 32'(dout0), 32'(hold0));
        if (p1v) hold1 = p1d;
        chk("d1_valid", 32'(dv1), 32'(p1v));
        chk("d1_dout", dout1, hold1);
        p1v = a1;
        p1d = x1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst  = 1'b1;
        en   = 1'b1;
        we   = 1'b0;
        be   = 4'h0;
        addr = 4'h0;
        din  = 32'h0;

        do_reset(2);

        // clear runs with en held high; the 12-word array
        // finishes early and serves out-of-range reads (zero)
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 32'h0, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 32'h0, 32'h0);
        end

        // write 3 = A5, read back
        step(1'b1, 1'b1, 4'h1, 4'd3, 32'h0000_00A5, 32'h00, 32'h0000_00A5);
        step(1'b1, 1'b0, 4'h0, 4'd3, 32'h0,         32'hA5, 32'h0000_00A5);

        // byte-lane merge on word 5
        step(1'b1, 1'b1, 4'hF, 4'd5, 32'h1122_3344, 32'h00, 32'h1122_3344);
        step(1'b1, 1'b1, 4'h5, 4'd5, 32'hAABB_CCDD, 32'h44, 32'h11BB_33DD);
        step(1'b1, 1'b0, 4'h0, 4'd5, 32'h0,         32'hDD, 32'h11BB_33DD);

        // write return old/new on word 7
        step(1'b1, 1'b1, 4'hF, 4'd7, 32'h12, 32'h00, 32'h12);
        step(1'b1, 1'b1, 4'hF, 4'd7, 32'h34, 32'h12, 32'h34);
        // be=0 no-op write still returns the word
        step(1'b1, 1'b1, 4'h0, 4'd7, 32'hFF, 32'h34, 32'h34);
        step(1'b1, 1'b0, 4'h0, 4'd7, 32'h0,  32'h34, 32'h34);

        // idle: outputs must hold
        step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0, 32'h0);

        // back-to-back write/read/read
        step(1'b1, 1'b1, 4'hF, 4'd9, 32'h77, 32'h00, 32'h77);
        step(1'b1, 1'b1, 4'hF, 4'd2, 32'h5A, 32'h00, 32'h5A);
        step(1'b1, 1'b0, 4'h0, 4'd2, 32'h0,  32'h5A, 32'h5A);
        step(1'b1, 1'b0, 4'h0, 4'd9, 32'h0,  32'h77, 32'h77);

        // addr 13: in range for the 16-word array only
        step(1'b1, 1'b1, 4'hF, 4'd13, 32'hCAFE_00FF, 32'h00, 32'h0);
        step(1'b1, 1'b0, 4'h0, 4'd13, 32'h0,         32'hFF, 32'h0);
        step(1'b0, 1'b0, 4'h0, 4'd0,  32'h0,         32'h0,  32'h0);

        // reset with a read in flight in the 2-cycle pipeline
        step(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 32'hA5, 32'h0000_00A5);
        addr = 4'd5;
        do_reset(1);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'h0, 32'h0);
        end
        step(1'b1, 1'b0, 4'h0, 4'd3,  32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 4'd5,  32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 4'd13, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 4'd9,  32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 4'd0,  32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 4'd0,  32'h0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
